// File: rtl/greenhouse_pkg.sv
// Shared state encodings and width helpers for the
// greenhouse actuator scheduler.
package greenhouse_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SERVE = 2'b01;
    localparam logic [1:0] ST_EMERG = 2'b10;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gh_channel_timer.sv
// Per-channel on-time and cooldown tracking.
// NO_LIMIT channels never time out and never cool down.
module gh_channel_timer
    import greenhouse_pkg::*;
#(
    parameter int MIN_ON   = 4,
    parameter int MAX_ON   = 16,
    parameter int COOLDOWN = 8,
    parameter bit NO_LIMIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic act_cur,
    input  logic act_nxt,
    input  logic start_cd,
    output logic can_release,
    output logic timeout,
    output logic blocked
);

    localparam int OW = cnt_w(MAX_ON);
    localparam int CW = cnt_w(COOLDOWN);

    logic [OW-1:0] on_cnt;
    logic [CW-1:0] cd_cnt;

    // on_cnt = cycles the actuator has been on, including this one;
    // cd_cnt counts down the blocked window after a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            on_cnt <= '0;
            cd_cnt <= '0;
        end else begin
            if (!act_nxt)
                on_cnt <= '0;
            else if (!act_cur)
                on_cnt <= OW'(1);
            else if (on_cnt != OW'(MAX_ON))
                on_cnt <= on_cnt + 1'b1;

            if (start_cd && !NO_LIMIT)
                cd_cnt <= CW'(COOLDOWN);
            else if (cd_cnt != '0)
                cd_cnt <= cd_cnt - 1'b1;
        end
    end

    assign can_release = on_cnt >= OW'(MIN_ON);
    assign timeout     = !NO_LIMIT && (on_cnt >= OW'(MAX_ON));
    // The timeout edge itself opens the first low cycle, so the last
    // count (1) no longer blocks: exactly COOLDOWN low cycles.
    assign blocked     = cd_cnt > CW'(1);

endmodule

// File: rtl/greenhouse_actuator_scheduler.sv
// Maps sensor requests to actuator enables with on-time limits,
// cooldown, a concurrency cap and an emergency override.
module greenhouse_actuator_scheduler
    import greenhouse_pkg::*;
#(
    parameter int N_CH       = 6,
    parameter int MIN_ON     = 4,
    parameter int MAX_ON     = 16,
    parameter int COOLDOWN   = 8,
    parameter int MAX_ACTIVE = 2,
    parameter int EMERG_CH   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            req,
    input  logic                       enable,
    input  logic                       fault_clr,
    output logic [N_CH-1:0]            act,
    output logic [1:0]                 state,
    output logic [cnt_w(N_CH)-1:0]     n_active,
    output logic [N_CH-1:0]            fault_ch
);

    localparam int NA_W = cnt_w(N_CH);

    logic [N_CH-1:0] can_rel;
    logic [N_CH-1:0] tmo;
    logic [N_CH-1:0] blk;
    logic [N_CH-1:0] tmo_hit;
    logic [N_CH-1:0] act_d;
    logic [1:0]      state_d;
    logic [NA_W-1:0] pop;
    int              kept;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        gh_channel_timer #(
            .MIN_ON   (MIN_ON),
            .MAX_ON   (MAX_ON),
            .COOLDOWN (COOLDOWN),
            .NO_LIMIT (i == EMERG_CH)
        ) u_timer (
            .clk         (clk),
            .reset       (reset),
            .act_cur     (act[i]),
            .act_nxt     (act_d[i]),
            .start_cd    (tmo_hit[i]),
            .can_release (can_rel[i]),
            .timeout     (tmo[i]),
            .blocked     (blk[i])
        );
    end

    // Emergency override, then release/timeout, then ascending grants.
    // On emergency exit the emergency bit releases in the normal path.
    always_comb begin
        act_d   = '0;
        tmo_hit = '0;
        state_d = state;
        kept    = 0;
        if (req[EMERG_CH]) begin
            act_d[EMERG_CH] = 1'b1;
            state_d         = ST_EMERG;
        end else if (state == ST_EMERG && !can_rel[EMERG_CH]) begin
            act_d[EMERG_CH] = 1'b1;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (act[i] && tmo[i]) begin
                    tmo_hit[i] = 1'b1;
                end else if (act[i] && (req[i] || !can_rel[i])) begin
                    act_d[i] = 1'b1;
                    kept     = kept + 1;
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                if (enable && req[i] && !act[i] && !blk[i] &&
                    kept < MAX_ACTIVE) begin
                    act_d[i] = 1'b1;
                    kept     = kept + 1;
                end
            end
            state_d = (act_d != '0) ? ST_SERVE : ST_IDLE;
        end
    end

    // Population count of the next actuator vector.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++)
            pop = pop + NA_W'(act_d[i]);
    end

    // Output registers; a timeout on the clear edge still sets its flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            act      <= '0;
            state    <= ST_IDLE;
            n_active <= '0;
            fault_ch <= '0;
        end else begin
            act      <= act_d;
            state    <= state_d;
            n_active <= pop;
            fault_ch <= (fault_clr ? '0 : fault_ch) | tmo_hit;
        end
    end

endmodule

// File: tb/tb_greenhouse_actuator_scheduler.sv
// Bench for greenhouse_actuator_scheduler: directed scenarios
// plus randomized traffic against an edge-indexed reference model.
module tb_greenhouse_actuator_scheduler;

    localparam int N  = 6;
    localparam int MN = 4;
    localparam int MX = 16;
    localparam int CD = 8;
    localparam int MA = 2;
    localparam int E  = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic         enable = 1'b1;
    logic         fault_clr = 1'b0;
    logic [N-1:0] act;
    logic [1:0]   state;
    logic [2:0]   n_active;
    logic [N-1:0] fault_ch;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    greenhouse_actuator_scheduler #(
        .N_CH(N), .MIN_ON(MN), .MAX_ON(MX), .COOLDOWN(CD),
        .MAX_ACTIVE(MA), .EMERG_CH(E)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .enable    (enable),
        .fault_clr (fault_clr),
        .act       (act),
        .state     (state),
        .n_active  (n_active),
        .fault_ch  (fault_ch)
    );

    always #5 clk = ~clk;

    // Reference model: absolute edge numbers for grants and for the
    // first edge at which a timed-out channel may be granted again.
    int           ecnt = 0;
    int           grant_at [N];
    int           elig_at  [N];
    logic [N-1:0] m_act   = '0;
    logic [N-1:0] m_fault = '0;
    int           m_state = 0;

    always @(posedge clk) begin : model
        logic [N-1:0] nxt;
        logic [N-1:0] tmo;
        int cnt;
        int dur;
        ecnt = ecnt + 1;
        if (reset) begin
            m_act   = '0;
            m_fault = '0;
            m_state = 0;
            for (int i = 0; i < N; i++) elig_at[i] = 0;
        end else begin
            nxt = '0;
            tmo = '0;
            if (req[E]) begin
                if (!m_act[E]) grant_at[E] = ecnt;
                nxt[E]  = 1'b1;
                m_state = 2;
            end else if (m_state == 2 && ecnt - grant_at[E] < MN) begin
                nxt[E] = 1'b1;
            end else begin
                cnt = 0;
                for (int i = 0; i < N; i++) begin
                    if (i != E && m_act[i]) begin
                        dur = ecnt - grant_at[i];
                        if (dur >= MX) begin
                            tmo[i]     = 1'b1;
                            elig_at[i] = ecnt + CD;
                        end else if (req[i] || dur < MN) begin
                            nxt[i] = 1'b1;
                            cnt++;
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (i != E && !m_act[i] && req[i] && enable &&
                        ecnt >= elig_at[i] && cnt < MA) begin
                        nxt[i]      = 1'b1;
                        grant_at[i] = ecnt;
                        cnt++;
                    end
                end
                m_state = (nxt != '0) ? 1 : 0;
            end
            m_fault = (fault_clr ? '0 : m_fault) | tmo;
            m_act   = nxt;
        end
    end

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string nm, input int dut_v, input int mdl_v,
                       input int exp_v);
        chk(nm, dut_v, exp_v);
        chk({nm, "_model"}, mdl_v, exp_v);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("act", int'(act), int'(m_act));
            chk("state", int'(state), m_state);
            chk("n_active", int'(n_active), $countones(m_act));
            chk("fault_ch", int'(fault_ch), int'(m_fault));
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic en = 1'b1,
                       input logic clr = 1'b0, input logic rst = 1'b0);
        req       = r;
        enable    = en;
        fault_clr = clr;
        reset     = rst;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;

        // 1: reset then single-cycle pulse on ch1
        cyc(6'b000000, 1, 0, 1);
        cyc(6'b000000, 1, 0, 1);
        lit("rst_act", act, m_act, 0);
        lit("rst_state", state, m_state, 0);
        cyc(6'b000010);
        lit("pulse_act0", act, m_act, 6'b000010);
        lit("pulse_state", state, m_state, 1);
        lit("pulse_n", n_active, $countones(m_act), 1);
        repeat (3) cyc(6'b000000);
        lit("pulse_act3", act, m_act, 6'b000010);
        cyc(6'b000000);
        lit("pulse_off", act, m_act, 0);
        lit("pulse_idle", state, m_state, 0);

        // 2: cap at two, freed slot reused on the same edge
        repeat (6) cyc(6'b000111);
        lit("cap_act", act, m_act, 6'b000011);
        cyc(6'b000110);
        lit("reuse_act", act, m_act, 6'b000110);
        lit("reuse_n", n_active, $countones(m_act), 2);
        repeat (5) cyc(6'b000000);
        lit("drain_act", act, m_act, 0);

        // 3: timeout, fault, cooldown, regrant
        for (int k = 0; k < 30; k++) begin
            cyc(6'b000100);
            if (k == 15) lit("to_last_on", act, m_act, 6'b000100);
            if (k == 16) begin
                lit("to_drop", act, m_act, 0);
                lit("to_fault", fault_ch, m_fault, 6'b000100);
            end
            if (k == 23) lit("cd_last_off", act, m_act, 0);
            if (k == 24) lit("cd_regrant", act, m_act, 6'b000100);
        end
        repeat (6) cyc(6'b000000);

        // 4: emergency preempts, holds MIN_ON, then regrants
        repeat (2) cyc(6'b000011);
        lit("pre_em", act, m_act, 6'b000011);
        cyc(6'b100011);
        lit("em_act", act, m_act, 6'b100000);
        lit("em_state", state, m_state, 2);
        lit("em_nofault", fault_ch, m_fault, 6'b000100);
        cyc(6'b100011);
        repeat (2) cyc(6'b000011);
        lit("em_hold", act, m_act, 6'b100000);
        cyc(6'b000011);
        lit("em_exit_act", act, m_act, 6'b000011);
        lit("em_exit_st", state, m_state, 1);

        // 5: reset while in emergency
        cyc(6'b100000);
        lit("em2_state", state, m_state, 2);
        cyc(6'b100000, 1, 0, 1);
        lit("emrst_act", act, m_act, 0);
        lit("emrst_state", state, m_state, 0);
        lit("emrst_fault", fault_ch, m_fault, 0);
        lit("emrst_n", n_active, $countones(m_act), 0);

        // 6: enable gating, then clear colliding with a timeout
        repeat (3) cyc(6'b001000, 0);
        lit("en0_act", act, m_act, 0);
        repeat (16) cyc(6'b000100);
        cyc(6'b000100, 1, 1);
        lit("clr_to_act", act, m_act, 0);
        lit("clr_to_fault", fault_ch, m_fault, 6'b000100);
        cyc(6'b000000, 1, 1);
        lit("clr_fault", fault_ch, m_fault, 0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [N-1:0] r;
            int fp;
            r  = req;
            fp = (n < 750) ? 7 : 23;
            for (int b = 0; b < N; b++)
                if (b != E && $urandom_range(fp) == 0) r[b] = ~r[b];
            if (r[E]) begin
                if ($urandom_range(3) == 0) r[E] = 1'b0;
            end else if ($urandom_range(79) == 0) begin
                r[E] = 1'b1;
            end
            cyc(r, $urandom_range(9) != 0, $urandom_range(29) == 0,
                $urandom_range(399) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
